mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single synchronous `memory` port between the instruction-fetch side and the load/store side of the RISC-V core, for the multi-cycle core variant that has one unified memory. It grants one requester per transaction with a request/grant handshake and returns read data with a valid strobe after a fixed memory latency. Data accesses have priority, and a starvation guard ensures fetch progress.

## Interface
- `WORD_LENGTH`, default 32: address and data width.
- `MEM_LATENCY`, default 1: cycles from address issue to valid `mem_data_out`; legal values are 1 to 7.
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch waits.

Clock and reset are one clock `clk`; reset `rst` is asynchronous and active-low.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  WORD_LENGTH  fetch address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  WORD_LENGTH  fetch data
- `d_req`  in  1  data request; held with its address, data and write enables stable until `d_gnt`
- `d_addr`  in  WORD_LENGTH  data address
- `d_wdata`  in  WORD_LENGTH  store data
- `d_we`  in  3  byte write-enable code, same encoding as control unit `mem_write_en`; 0 means load
- `d_gnt`  out  1  data access accepted this cycle
- `d_rvalid`  out  1  load data valid or store complete
- `d_rdata`  out  WORD_LENGTH  load data
- `mem_address`  out  WORD_LENGTH  to memory `address`
- `mem_write_data`  out  WORD_LENGTH  to memory `write_data`
- `mem_write_enable`  out  3  to memory `write_enable`
- `mem_read_enable`  out  1  to memory `read_enable`
- `mem_data_out`  in  WORD_LENGTH  from memory `data_out`

## Operation
- The arbiter has two states:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding; `owner` ∈ {IF, D}; `lat_cnt` counts down from MEM_LATENCY.
- Grant is possible when state is IDLE, or in WAIT when `lat_cnt`==1 (the response cycle). This allows back-to-back transactions.
- Priority rules:
  - If both requests are asserted, D wins unless `starve_cnt`==STARVE_LIMIT; in that case IF wins.
  - If only one request is asserted, it wins.
- `starve_cnt` update:
  - Increments, saturating at STARVE_LIMIT, on each D grant while `if_req` is high.
  - Clears on an IF grant or whenever `if_req` is low.
- In the grant cycle, the memory outputs are driven combinationally from the winner:
  - IF: `mem_address`=`if_addr`, `mem_read_enable`=1, `mem_write_enable`=0.
  - D: `mem_address`=`d_addr`, `mem_write_data`=`d_wdata`, `mem_write_enable`=`d_we`, `mem_read_enable`=(`d_we`==0).
- In non-grant cycles, all memory enables are 0 and `mem_address`/`mem_write_data` are 0.
- After a grant, the arbiter enters WAIT with `lat_cnt`=MEM_LATENCY and `owner` set to the winner. `lat_cnt` decrements each cycle in WAIT.
- When `lat_cnt`==1, the owner's `*_rvalid` is 1 and `*_rdata`=`mem_data_out`. If no new grant occurs that cycle, the next state is IDLE.
- `d_rvalid` pulses for stores too, as the completion acknowledgement. `d_rdata` is don't-care for stores.
- `*_rdata` is `mem_data_out` passthrough. It is only meaningful with the matching rvalid.
- At most one transaction is outstanding. The arbiter does no address decode or byte steering; `memory_helper` stays downstream.

## Timing
- Grant in cycle T produces the memory request in T and rvalid in T+MEM_LATENCY.
- Peak throughput is one transaction per MEM_LATENCY cycles.
- Grants and memory enables are combinational from the requests and the registered state. Rvalid is decoded from the registered state only.
- Reset value of every output:
  - `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_read_enable`, `mem_write_enable`, `mem_address`, `mem_write_data` are 0.
  - `*_rdata` follows `mem_data_out`.
- Reset value of internal state: state IDLE, `owner` NONE, `lat_cnt` 0, `starve_cnt` 0.
- Reset asserted mid-transaction drops the outstanding response: no rvalid is produced after reset deasserts.
- A request that deasserts before its grant is a protocol violation; behaviour is unspecified, but the arbiter must not lock up.
- Simultaneous response and new request: the response rvalid and the new grant occur in the same cycle. The new owner takes effect at the next clock edge.

## Structure
- Shared package `risc_v_mem_pkg` holds:
  - `arb_state_t` {IDLE, WAIT}
  - `arb_owner_t` {NONE, IF, D}
  - `WORD_LENGTH`
  - `MEM_WE_NONE`=3'b0
- One sub-module, `mem_arb_select`, contains the priority pick plus the `starve_cnt` register. Its output is the one-hot winner {if_win, d_win}.
- Top-level `mem_port_arbiter` holds the FSM, `lat_cnt`, the output muxes and the rvalid decode.

## Test plan
- Single fetch, MEM_LATENCY=1: `if_req`=1, `if_addr`=0x10 → `if_gnt` in T, `mem_address`=0x10 with `mem_read_enable`=1 in T; `if_rvalid`=1 with `if_rdata` = memory word @0x10 in T+1.
- Store then load, MEM_LATENCY=2: `d_req` with `d_addr`=0x40, `d_wdata`=0xDEADBEEF, `d_we`=3'b111 → `mem_write_enable`=3'b111 in T, `d_rvalid` in T+2; load of 0x40 → `d_rdata`=0xDEADBEEF.
- Contention, STARVE_LIMIT=4: `if_req` and `d_req` held high continuously → grant sequence D,D,D,D,IF,D,D,D,D,IF, …
- Back-to-back, MEM_LATENCY=3: fetches issued every cycle → grants in T, T+3, T+6; `if_rvalid` in T+3, T+6, T+9; the rvalid and the next grant coincide.
- Reset mid-operation: `rst`=0 at T+1 after a grant at T with MEM_LATENCY=3 → all outputs 0, no rvalid after release; the next request is granted from IDLE.
- Idle: no requests for 10 cycles → memory enables stay 0 and `starve_cnt` stays 0.

Source files
------------

// File: rtl/risc_v_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// Holds FSM state/owner enums, data width and write-enable constants.
package risc_v_mem_pkg;

  localparam int WORD_LENGTH = 32;
  localparam logic [2:0] MEM_WE_NONE = 3'b000;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    IF,
    D
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Priority pick between fetch and data with a fetch starvation guard.
// Ports: clk, rst (async low), if_req, d_req, grant_ok -> if_win, d_win.
module mem_arb_select
  import risc_v_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_ok,
  output logic if_win,
  output logic d_win
);

  localparam int SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == LIMIT);

  // Data wins ties until fetch has waited through LIMIT data grants.
  always_comb begin
    if_win = grant_ok & if_req & (~d_req | starved);
    d_win  = grant_ok & d_req & ~(if_req & starved);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_win) begin
      starve_cnt <= '0;
    end else if (d_win && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch and load/store.
// Ports: if_* fetch side, d_* data side, mem_* memory side, clk/rst.
module mem_port_arbiter #(
  parameter int WORD_LENGTH  = risc_v_mem_pkg::WORD_LENGTH,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [WORD_LENGTH-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [WORD_LENGTH-1:0] if_rdata,
  input  logic                   d_req,
  input  logic [WORD_LENGTH-1:0] d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  input  logic [2:0]             d_we,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic [WORD_LENGTH-1:0] mem_address,
  output logic [WORD_LENGTH-1:0] mem_write_data,
  output logic [2:0]             mem_write_enable,
  output logic                   mem_read_enable,
  input  logic [WORD_LENGTH-1:0] mem_data_out
);

  import risc_v_mem_pkg::*;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  arb_state_t state;
  arb_owner_t owner;
  logic [2:0] lat_cnt;
  logic       resp;
  logic       grant_ok;
  logic       if_win;
  logic       d_win;

  // Response cycle doubles as a grant slot for back-to-back issue.
  assign resp     = (state == WAIT) && (lat_cnt == 3'd1);
  assign grant_ok = rst && ((state == IDLE) || resp);

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .d_req   (d_req),
    .grant_ok(grant_ok),
    .if_win  (if_win),
    .d_win   (d_win)
  );

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign if_rvalid = resp && (owner == IF);
  assign d_rvalid  = resp && (owner == D);
  assign if_rdata  = mem_data_out;
  assign d_rdata   = mem_data_out;

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = MEM_WE_NONE;
    mem_read_enable  = 1'b0;
    unique case (1'b1)
      if_win: begin
        mem_address     = if_addr;
        mem_read_enable = 1'b1;
      end
      d_win: begin
        mem_address      = d_addr;
        mem_write_data   = d_wdata;
        mem_write_enable = d_we;
        mem_read_enable  = (d_we == MEM_WE_NONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= NONE;
      lat_cnt <= '0;
    end else if (if_win || d_win) begin
      state   <= WAIT;
      owner   <= if_win ? IF : D;
      lat_cnt <= LAT;
    end else if (state == WAIT) begin
      if (lat_cnt == 3'd1) begin
        state   <= IDLE;
        owner   <= NONE;
        lat_cnt <= '0;
      end else begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter at latencies 1, 2 and 3.
// Shared stimulus; each vector is checked against one chosen instance.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_we;

  logic [2:0]        ig, dg, irv, drv, re;
  logic [2:0][2:0]   we;
  logic [2:0][31:0]  maddr, mwd, ird, drd, mdo;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mem [0:63];
    logic [31:0] pipe [0:2];

    mem_port_arbiter #(
      .WORD_LENGTH (32),
      .MEM_LATENCY (g + 1),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .if_req          (if_req),
      .if_addr         (if_addr),
      .if_gnt          (ig[g]),
      .if_rvalid       (irv[g]),
      .if_rdata        (ird[g]),
      .d_req           (d_req),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_we            (d_we),
      .d_gnt           (dg[g]),
      .d_rvalid        (drv[g]),
      .d_rdata         (drd[g]),
      .mem_address     (maddr[g]),
      .mem_write_data  (mwd[g]),
      .mem_write_enable(we[g]),
      .mem_read_enable (re[g]),
      .mem_data_out    (mdo[g])
    );

    // Synchronous memory: word i holds A500_0000 | byte address.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i * 4);
        for (int i = 0; i < 3; i++) pipe[i] <= '0;
      end else begin
        if (we[g] != 3'd0) mem[maddr[g][7:2]] <= mwd[g];
        if (re[g]) pipe[0] <= mem[maddr[g][7:2]];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
    end

    assign mdo[g] = pipe[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rb;
    int          sel;
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [2:0]  dwe;
    bit [1:0]    g;
    bit [1:0]    rv;
    bit          crd;
    logic [31:0] erd;
  } vec_t;

  localparam bit [1:0] G0 = 2'b00, GI = 2'b10, GD = 2'b01;
  localparam bit [1:0] R0 = 2'b00, RI = 2'b10, RD = 2'b01;

  vec_t tab[$];
  int   checks;
  int   errors;
  int   cur;

  function automatic void add(bit rb, int sel, bit ir, logic [31:0] ia,
                              bit dr, logic [31:0] da, logic [31:0] dwd,
                              logic [2:0] dwe, bit [1:0] g, bit [1:0] rv,
                              bit crd, logic [31:0] erd);
    vec_t v;
    v.rb = rb; v.sel = sel; v.ir = ir; v.ia = ia;
    v.dr = dr; v.da = da; v.dwd = dwd; v.dwe = dwe;
    v.g = g; v.rv = rv; v.crd = crd; v.erd = erd;
    tab.push_back(v);
  endfunction

  function automatic void idle(int sel, bit [1:0] rv, logic [31:0] erd);
    add(0, sel, 0, 0, 0, 0, 0, 0, G0, rv, rv != R0, erd);
  endfunction

  // Both sides requesting: fetch 0x20, load 0x80.
  function automatic void cont(bit [1:0] g, bit [1:0] rv);
    add(0, 0, 1, 32'h20, 1, 32'h80, 32'h1111_2222, 3'd0, g, rv,
        rv != R0, (rv == RI) ? 32'hA500_0020 : 32'hA500_0080);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, cur, act, exp);
    end
  endtask

  task automatic do_reset(int sel);
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h40; d_wdata = 32'hFFFF_FFFF; d_we = 3'b111;
    #1;
    chk("rst_if_gnt", 32'(ig[sel]), 0);
    chk("rst_d_gnt", 32'(dg[sel]), 0);
    chk("rst_if_rvalid", 32'(irv[sel]), 0);
    chk("rst_d_rvalid", 32'(drv[sel]), 0);
    chk("rst_mem_re", 32'(re[sel]), 0);
    chk("rst_mem_we", 32'(we[sel]), 0);
    chk("rst_mem_addr", maddr[sel], 0);
    chk("rst_mem_wdata", mwd[sel], 0);
    chk("rst_if_rdata", ird[sel], mdo[sel]);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic apply(vec_t v);
    logic [31:0] ea, ew;
    logic [2:0]  ewe;
    logic        ere;
    int          s;
    s = v.sel;
    if (v.rb) do_reset(s);
    @(negedge clk);
    if_req = v.ir; if_addr = v.ia;
    d_req = v.dr; d_addr = v.da; d_wdata = v.dwd; d_we = v.dwe;
    #1;
    ea = '0; ew = '0; ewe = 3'd0; ere = 1'b0;
    if (v.g == GI) begin
      ea = v.ia; ere = 1'b1;
    end else if (v.g == GD) begin
      ea = v.da; ew = v.dwd; ewe = v.dwe; ere = (v.dwe == 3'd0);
    end
    chk("if_gnt", 32'(ig[s]), 32'(v.g[1]));
    chk("d_gnt", 32'(dg[s]), 32'(v.g[0]));
    chk("if_rvalid", 32'(irv[s]), 32'(v.rv[1]));
    chk("d_rvalid", 32'(drv[s]), 32'(v.rv[0]));
    chk("mem_re", 32'(re[s]), 32'(ere));
    chk("mem_we", 32'(we[s]), 32'(ewe));
    chk("mem_addr", maddr[s], ea);
    chk("mem_wdata", mwd[s], ew);
    if (v.crd && v.rv[1]) chk("if_rdata", ird[s], v.erd);
    if (v.crd && v.rv[0]) chk("d_rdata", drd[s], v.erd);
  endtask

  initial begin
    checks = 0; errors = 0; cur = 0;
    rst = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0; d_we = 0;

    // Latency 1: single fetch, contention, idle clears starvation.
    add(1, 0, 1, 32'h10, 0, 0, 0, 0, GI, R0, 0, 0);
    idle(0, RI, 32'hA500_0010);
    idle(0, R0, 0);
    for (int k = 0; k < 10; k++)
      cont((k % 5 == 4) ? GI : GD,
           (k == 0) ? R0 : (((k - 1) % 5 == 4) ? RI : RD));
    idle(0, RI, 32'hA500_0020);
    for (int k = 0; k < 3; k++) cont(GD, (k == 0) ? R0 : RD);
    idle(0, RD, 32'hA500_0080);
    for (int k = 0; k < 9; k++) idle(0, R0, 0);
    for (int k = 0; k < 5; k++)
      cont((k == 4) ? GI : GD, (k == 0) ? R0 : RD);
    idle(0, RI, 32'hA500_0020);

    // Latency 2: store then load overlapping the store ack.
    add(1, 1, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 3'b111, GD, R0, 0, 0);
    idle(1, R0, 0);
    add(0, 1, 0, 0, 1, 32'h40, 0, 3'b000, GD, RD, 0, 0);
    idle(1, R0, 0);
    idle(1, RD, 32'hDEAD_BEEF);
    idle(1, R0, 0);

    // Latency 3: fetch held every cycle, grants every third cycle.
    for (int k = 0; k < 10; k++)
      add(k == 0, 2, 1, 32'h30, 0, 0, 0, 0,
          (k % 3 == 0) ? GI : G0, (k > 0 && k % 3 == 0) ? RI : R0,
          1, 32'hA500_0030);
    idle(2, R0, 0);

    foreach (tab[i]) begin
      cur = i;
      apply(tab[i]);
    end

    // Reset one cycle after a latency-3 grant drops the response.
    cur = -1;
    do_reset(2);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h30;
    #1 chk("mid_gnt", 32'(ig[2]), 1);
    @(negedge clk);
    if_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(ig[2]), 0);
    chk("mid_rst_re", 32'(re[2]), 0);
    chk("mid_rst_addr", maddr[2], 0);
    chk("mid_rst_rvalid", 32'(irv[2]), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_if_rvalid", 32'(irv[2]), 0);
      chk("post_rst_d_rvalid", 32'(drv[2]), 0);
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h34;
    #1;
    chk("post_rst_gnt", 32'(ig[2]), 1);
    chk("post_rst_addr", maddr[2], 32'h34);
    @(negedge clk);
    if_req = 1'b0;
    #1 chk("post_rst_wait1", 32'(irv[2]), 0);
    @(negedge clk);
    #1 chk("post_rst_wait2", 32'(irv[2]), 0);
    @(negedge clk);
    #1;
    chk("post_rst_rvalid", 32'(irv[2]), 1);
    chk("post_rst_rdata", ird[2], 32'hA500_0034);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
